mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 14 +
 rtl/mux_arb_hold_cnt.sv | 28 ++
 rtl/mux_arbiter.sv | 97 +++++++++
 tb/tb_mux_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types for the two-requester mux arbiter: FSM state encoding and
// the select encoding driven onto sel.
package mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter for the arbiter timeout. Counts cycles spent in
// one grant state; clr restarts it from zero, at_max flags MAX_HOLD-1.
// Only instantiated when MUX_ARB_TIMEOUT_EN is defined.
module mux_arb_hold_cnt #(
   parameter int MAX_HOLD = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic at_max
);

   localparam int            CW  = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] TOP = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt;

   // count up while in a grant, stop at TOP, restart on clear or reset
   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         cnt <= '0;
      else if (cnt != TOP)
         cnt <= cnt + 1'b1;
   end

   assign at_max = (cnt == TOP);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter steering a or b onto a registered output.
// Ties from IDLE go to the requester that did not win last; a grant is kept
// while its owner holds req and passes straight to a pending peer on release.
// Define MUX_ARB_TIMEOUT_EN to force a handover after MAX_HOLD grant cycles
// when the other requester is waiting.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   state_t state, state_nx;
   logic   last_b, last_b_nx;   // 1 = B won the most recent grant
   logic   timeout;

`ifdef MUX_ARB_TIMEOUT_EN
   logic hold_clr;

   // counter only runs inside a grant and restarts on every state change
   assign hold_clr = (state == IDLE) || (state_nx != state);

   mux_arb_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (hold_clr),
      .at_max (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // state and fairness history; reset leaves B as last winner so A wins the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_b <= 1'b1;
      end else begin
         state  <= state_nx;
         last_b <= last_b_nx;
      end
   end

   // next-state: hold while owner requests, hand over directly when peer waits
   always_comb begin
      state_nx  = state;
      last_b_nx = last_b;
      unique case (state)
         IDLE: begin
            if (req_a && req_b) state_nx = last_b ? GRANT_A : GRANT_B;
            else if (req_a)     state_nx = GRANT_A;
            else if (req_b)     state_nx = GRANT_B;
         end
         GRANT_A: begin
            if (req_b && (!req_a || timeout)) state_nx = GRANT_B;
            else if (!req_a)                  state_nx = IDLE;
         end
         GRANT_B: begin
            if (req_a && (!req_b || timeout)) state_nx = GRANT_A;
            else if (!req_b)                  state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (state_nx == GRANT_A && state != GRANT_A) last_b_nx = 1'b0;
      if (state_nx == GRANT_B && state != GRANT_B) last_b_nx = 1'b1;
   end

   // grants decode straight from the state register, so they are glitch-free flops
   assign gnt_a = (state == GRANT_A);
   assign gnt_b = (state == GRANT_B);
   assign sel   = gnt_b ? SEL_B : SEL_A;

   // output register: capture selected source during a grant, hold otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= gnt_a | gnt_b;
         if (gnt_a | gnt_b)
            out <= (sel == SEL_B) ? b : a;
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter (MAX_HOLD=4). Grant expectations are checked per
// cycle by each scenario task; output data goes through a scoreboard queue
// filled from the expected owner and popped when out is sampled.
module tb_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       gnt_a, gnt_b, sel, out_valid;
   logic [7:0] out;

   int total = 0;
   int bad   = 0;
   int exp_own = 0;          // expected owner this cycle: 0 none, 1 A, 2 B
   bit mon_en = 1'b0;
   logic [7:0] sbq[$];
   logic [7:0] exp_hold = '0;

   typedef struct {
      logic       ra, rb;
      logic [7:0] da, db;
      int         eo;        // owner expected after the next edge
   } step_t;

   mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
      .a(a), .b(b), .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
      .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // scoreboard producer: data presented during an expected grant is due on out
   always @(posedge clk) begin
      if (!rst_n) begin
         sbq.delete();
         exp_hold = '0;
      end else if (exp_own == 1) sbq.push_back(a);
      else if (exp_own == 2) sbq.push_back(b);
   end

   // scoreboard consumer: one output beat per queued item, else hold
   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (sbq.size() != 0) begin
            logic [7:0] e;
            e = sbq.pop_front();
            if (out_valid !== 1'b1 || out !== e) begin
               bad++;
               $display("FAIL data out=%h valid=%b want out=%h valid=1", out, out_valid, e);
            end
            exp_hold = e;
         end else if (out_valid !== 1'b0 || out !== exp_hold) begin
            bad++;
            $display("FAIL hold out=%h valid=%b want out=%h valid=0", out, out_valid, exp_hold);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; exp_own = 0;
      @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      total++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || sel !== 1'b0 || out !== 8'h00 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset gnt_a=%b gnt_b=%b sel=%b out=%h valid=%b want all 0",
                  gnt_a, gnt_b, sel, out, out_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      exp_own = 1;
      total++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_release gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b);
      end
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
      exp_own = 0;
      total++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle gnt_a=%b gnt_b=%b want 0 0", gnt_a, gnt_b);
      end
   endtask

   task automatic test_single();
      step_t st[5];
      st = '{'{1'b1, 1'b0, 8'h3C, 8'h00, 1}, '{1'b1, 1'b0, 8'h3C, 8'h00, 1},
             '{1'b0, 1'b0, 8'h3C, 8'h00, 0}, '{1'b0, 1'b0, 8'hFF, 8'h00, 0},
             '{1'b0, 1'b0, 8'hFF, 8'h00, 0}};
      for (int i = 0; i < 5; i++) begin
         req_a = st[i].ra; req_b = st[i].rb; a = st[i].da; b = st[i].db;
         @(negedge clk);
         exp_own = st[i].eo;
         total++;
         if (gnt_a !== (exp_own == 1) || gnt_b !== (exp_own == 2) || sel !== (exp_own == 2)) begin
            bad++;
            $display("FAIL single[%0d] gnt_a=%b gnt_b=%b sel=%b want owner %0d", i, gnt_a, gnt_b, sel, exp_own);
         end
      end
   endtask

   task automatic test_tie();
      step_t st[10];
      st = '{'{1'b0, 1'b1, 8'h00, 8'hB1, 2}, '{1'b0, 1'b0, 8'h00, 8'hB1, 0},
             '{1'b1, 1'b1, 8'h11, 8'h22, 1}, '{1'b1, 1'b1, 8'h12, 8'h22, 1},
             '{1'b1, 1'b1, 8'h13, 8'h22, 1}, '{1'b0, 1'b1, 8'h14, 8'h23, 2},
             '{1'b0, 1'b1, 8'h14, 8'h24, 2}, '{1'b0, 1'b0, 8'h14, 8'h25, 0},
             '{1'b1, 1'b1, 8'h31, 8'h41, 1}, '{1'b0, 1'b0, 8'h31, 8'h41, 0}};
      for (int i = 0; i < 10; i++) begin
         req_a = st[i].ra; req_b = st[i].rb; a = st[i].da; b = st[i].db;
         @(negedge clk);
         exp_own = st[i].eo;
         total++;
         if (gnt_a !== (exp_own == 1) || gnt_b !== (exp_own == 2) || sel !== (exp_own == 2)) begin
            bad++;
            $display("FAIL tie[%0d] gnt_a=%b gnt_b=%b sel=%b want owner %0d", i, gnt_a, gnt_b, sel, exp_own);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t st[7];
      st = '{'{1'b1, 1'b0, 8'h51, 8'h00, 1}, '{1'b1, 1'b1, 8'h52, 8'h61, 1},
             '{1'b0, 1'b1, 8'h53, 8'h62, 2}, '{1'b1, 1'b1, 8'h54, 8'h63, 2},
             '{1'b1, 1'b1, 8'h55, 8'h64, 2}, '{1'b1, 1'b0, 8'h56, 8'h65, 1},
             '{1'b0, 1'b0, 8'h57, 8'h66, 0}};
      for (int i = 0; i < 7; i++) begin
         req_a = st[i].ra; req_b = st[i].rb; a = st[i].da; b = st[i].db;
         @(negedge clk);
         exp_own = st[i].eo;
         total++;
         if (gnt_a !== (exp_own == 1) || gnt_b !== (exp_own == 2) || sel !== (exp_own == 2)) begin
            bad++;
            $display("FAIL b2b[%0d] gnt_a=%b gnt_b=%b sel=%b want owner %0d", i, gnt_a, gnt_b, sel, exp_own);
         end
      end
   endtask

   task automatic test_reset_mid();
      req_a = 1'b0; req_b = 1'b1; b = 8'hA5;
      @(negedge clk);
      exp_own = 2;
      total++;
      if (gnt_b !== 1'b1 || sel !== 1'b1) begin
         bad++;
         $display("FAIL rmid_grant gnt_b=%b sel=%b want 1 1", gnt_b, sel);
      end
      rst_n = 1'b0;
      @(negedge clk);
      exp_own = 0;
      total++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || sel !== 1'b0 || out_valid !== 1'b0 || out !== 8'h00) begin
         bad++;
         $display("FAIL rmid_abort gnt_a=%b gnt_b=%b sel=%b valid=%b out=%h want 0 0 0 0 00",
                  gnt_a, gnt_b, sel, out_valid, out);
      end
      rst_n = 1'b1; req_b = 1'b0;
      @(negedge clk);
      total++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
         bad++;
         $display("FAIL rmid_idle gnt_a=%b gnt_b=%b want 0 0", gnt_a, gnt_b);
      end
   endtask

   task automatic test_timeout();
      req_a = 1'b1; req_b = 1'b0; a = 8'h70; b = 8'h80;
      @(negedge clk);
      exp_own = 1;
      total++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
         bad++;
         $display("FAIL tmo_cyc1 gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b);
      end
      req_b = 1'b1;
      for (int k = 2; k <= 8; k++) begin
         a = 8'h70 + 8'(k); b = 8'h80 + 8'(k);
         @(negedge clk);
`ifdef MUX_ARB_TIMEOUT_EN
         exp_own = (k <= 4) ? 1 : 2;
`else
         exp_own = 1;
`endif
         total++;
         if (gnt_a !== (exp_own == 1) || gnt_b !== (exp_own == 2) || sel !== (exp_own == 2)) begin
            bad++;
            $display("FAIL tmo[%0d] gnt_a=%b gnt_b=%b sel=%b want owner %0d", k, gnt_a, gnt_b, sel, exp_own);
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
      exp_own = 0;
      total++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
         bad++;
         $display("FAIL tmo_idle gnt_a=%b gnt_b=%b want 0 0", gnt_a, gnt_b);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      repeat (3) @(negedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain queued=%0d want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
